// File: rtl/relin_keyswitch_pkg.sv
// Shared types, constants and modular-arithmetic helpers for the
// relinearization key-switch stage.
//   word_t     : one coefficient, values in [0,Q) after reduction
//   vec_t      : N coefficients
//   wide_vec_t : N coefficients at digit*key product width
//   CT_t       : degree-1 ciphertext (a, b)
//   state_t    : key-switch FSM states
package relin_keyswitch_pkg;

    localparam int N          = 4;
    localparam int Q          = 17;
    localparam int BASE       = 4;
    localparam int NUM_DIGITS = 3;
    localparam int LOG_BASE   = $clog2(BASE);
    localparam int W          = $clog2(Q);
    localparam int WW         = W + LOG_BASE;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [W:0]       Q_ADD      = Q[W:0];
    localparam logic [WW-1:0]    Q_WIDE     = Q[WW-1:0];
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    // Elaboration-time sanity of the gadget parameters.
    localparam bit BASE_IS_POW2   = (BASE == (1 << LOG_BASE));
    localparam bit DIGITS_COVER_Q = ((BASE ** NUM_DIGITS) > Q);

    typedef logic [W-1:0]           word_t;
    typedef logic [N-1:0][W-1:0]    vec_t;
    typedef logic [N-1:0][WW-1:0]   wide_vec_t;

    typedef struct packed {
        vec_t a;
        vec_t b;
    } CT_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECOMP = 2'd1,
        FINAL  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reduce a product-width value into [0,Q).
    function automatic word_t reduce_mod_q(input logic [WW-1:0] x);
        logic [WW-1:0] r;
        r = x % Q_WIDE;
        return r[W-1:0];
    endfunction

    // Both operands are already in [0,Q), so one conditional subtract suffices.
    function automatic word_t add_mod_q(input word_t a, input word_t b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_ADD) begin
            s = s - Q_ADD;
        end
        return s[W-1:0];
    endfunction

endpackage

// File: rtl/relin_keyswitch_gadget_digit_mac.sv
// gadget_digit_mac: one coefficient lane of the digit multiply-accumulate.
//   acc      : running accumulator, in [0,Q)
//   digit    : current base-BASE digit of the residual
//   key      : matching relinearization-key coefficient (any W-bit value)
//   acc_next : (acc + digit*key) mod Q
module gadget_digit_mac
    import relin_keyswitch_pkg::*;
(
    input  word_t               acc,
    input  logic [LOG_BASE-1:0] digit,
    input  word_t               key,
    output word_t               acc_next
);

    logic [WW-1:0] prod;

    assign prod     = {{W{1'b0}}, digit} * {{LOG_BASE{1'b0}}, key};
    assign acc_next = add_mod_q(acc, reduce_mod_q(prod));

endmodule

// File: rtl/relin_keyswitch.sv
// relin_keyswitch: turns a degree-2 product (d0, d1, d2) into a degree-1
// ciphertext by gadget-decomposing d2 one digit per cycle and accumulating
// each digit against the relinearization key pair for that digit.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid/in_ready : input handshake for in_d0/in_d1/in_d2
//   key_idx           : digit index whose key pair must appear on key_a/key_b
//                       in the same cycle (combinational lookup outside)
//   out_valid/out_ready, out_ct : result handshake and ciphertext
//   state_dbg         : current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// where out_ct stays constant until out_ready is seen; no new input is taken
// in the DONE cycle even when the output transfer happens then.
module relin_keyswitch
    import relin_keyswitch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  vec_t             in_d0,
    input  vec_t             in_d1,
    input  vec_t             in_d2,
    output logic [CNT_W-1:0] key_idx,
    input  vec_t             key_a,
    input  vec_t             key_b,
    output logic             out_valid,
    input  logic             out_ready,
    output CT_t              out_ct,
    output state_t           state_dbg
);

    if (!BASE_IS_POW2) begin : g_base_check
        $error("BASE must be a power of two");
    end
    if (!DIGITS_COVER_Q) begin : g_digit_check
        $error("BASE**NUM_DIGITS must exceed Q");
    end

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    vec_t             d0_q, d1_q, residual;
    vec_t             acc_a, acc_b;
    vec_t             acc_a_next, acc_b_next;
    CT_t              ct_q;

    // Two MAC lanes per coefficient; the low digit of the residual drives both.
    for (genvar j = 0; j < N; j++) begin : g_lane
        gadget_digit_mac u_mac_a (
            .acc      (acc_a[j]),
            .digit    (residual[j][LOG_BASE-1:0]),
            .key      (key_a[j]),
            .acc_next (acc_a_next[j])
        );
        gadget_digit_mac u_mac_b (
            .acc      (acc_b[j]),
            .digit    (residual[j][LOG_BASE-1:0]),
            .key      (key_b[j]),
            .acc_next (acc_b_next[j])
        );
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        key_idx    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = DECOMP;
                end
            end
            DECOMP: begin
                key_idx = cnt;
                if (cnt == LAST_DIGIT) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            d0_q     <= '0;
            d1_q     <= '0;
            residual <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            ct_q     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < N; j++) begin
                            d0_q[j]     <= reduce_mod_q({{LOG_BASE{1'b0}}, in_d0[j]});
                            d1_q[j]     <= reduce_mod_q({{LOG_BASE{1'b0}}, in_d1[j]});
                            residual[j] <= reduce_mod_q({{LOG_BASE{1'b0}}, in_d2[j]});
                        end
                        acc_a <= '0;
                        acc_b <= '0;
                        cnt   <= '0;
                    end
                end
                DECOMP: begin
                    acc_a <= acc_a_next;
                    acc_b <= acc_b_next;
                    for (int j = 0; j < N; j++) begin
                        residual[j] <= residual[j] >> LOG_BASE;
                    end
                    cnt <= cnt + 1'b1;
                end
                FINAL: begin
                    for (int j = 0; j < N; j++) begin
                        ct_q.b[j] <= add_mod_q(d0_q[j], acc_b[j]);
                        ct_q.a[j] <= add_mod_q(d1_q[j], acc_a[j]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_ct    = ct_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_relin_keyswitch.sv
// Bench for relin_keyswitch: directed cases plus a long random run, with a
// scoreboard queue filled by the driver and drained by an output monitor.
module tb_relin_keyswitch;
    import relin_keyswitch_pkg::*;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    vec_t             in_d0, in_d1, in_d2;
    logic [CNT_W-1:0] key_idx;
    vec_t             key_a, key_b;
    logic             out_valid;
    logic             out_ready;
    CT_t              out_ct;
    state_t           state_dbg;

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    relin_keyswitch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .key_idx   (key_idx),
        .key_a     (key_a),
        .key_b     (key_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .state_dbg (state_dbg)
    );

    // ---------------- key ROM ----------------
    vec_t ka_rom [NUM_DIGITS];
    vec_t kb_rom [NUM_DIGITS];

    always_comb begin
        key_a = '0;
        key_b = '0;
        if (int'(key_idx) < NUM_DIGITS) begin
            key_a = ka_rom[int'(key_idx)];
            key_b = kb_rom[int'(key_idx)];
        end
    end

    // ---------------- scoreboard ----------------
    logic [$bits(CT_t)-1:0] exp_q[$];
    int checks    = 0;
    int errors    = 0;
    int out_count = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: integer arithmetic straight from the decomposition rule.
    function automatic CT_t model(input vec_t d0, input vec_t d1, input vec_t d2);
        CT_t r;
        for (int j = 0; j < N; j++) begin
            int res, sa, sb, dig;
            res = int'(d2[j]) % Q;
            sa  = 0;
            sb  = 0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = res % BASE;
                res = res / BASE;
                sa  = sa + dig * int'(ka_rom[i][j]);
                sb  = sb + dig * int'(kb_rom[i][j]);
            end
            r.a[j] = word_t'((int'(d1[j]) + sa) % Q);
            r.b[j] = word_t'((int'(d0[j]) + sb) % Q);
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = word_t'($urandom_range(0, (1 << W) - 1));
        return v;
    endfunction

    function automatic vec_t fill(input int x);
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = word_t'(x);
        return v;
    endfunction

    task automatic rand_keys();
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ka_rom[i] = rand_vec();
            kb_rom[i] = rand_vec();
        end
    endtask

    // Output monitor: every accepted output pops one expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h with no expectation pending", out_ct);
            end else begin
                check("out_ct", 64'(out_ct), 64'(exp_q.pop_front()));
                out_count++;
            end
        end
    end

    // Optional random backpressure.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input vec_t d0, input vec_t d1, input vec_t d2,
                        input CT_t exp, output int hs_c);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_d0    = d0;
        in_d1    = d1;
        in_d2    = d2;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            guard++;
            if (guard > 40) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, need 1", in_ready, guard);
                break;
            end
        end
        hs_c = cycle;
        if (guard <= 40) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int v_c);
        int guard;
        guard = 0;
        v_c   = -1;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                v_c = cycle;
                break;
            end
            guard++;
            if (guard > 40) begin
                checks++;
                errors++;
                $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, need 1", out_valid, guard);
                break;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int guard;
        guard = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > budget) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d results outstanding, need 0", exp_q.size());
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   hs_c, v_c, base_count;
        CT_t  e, held;
        vec_t d0, d1, d2;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_d0     = '0;
        in_d1     = '0;
        in_d2     = '0;
        rand_keys();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  64'(in_ready),  64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_ct",    64'(out_ct),    64'(0));
        check("reset_key_idx",   64'(key_idx),   64'(0));
        check("reset_state",     64'(state_dbg), 64'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // D2 = 0: result is D0/D1 unchanged; latency and key_idx sequence.
        for (int j = 0; j < N; j++) begin
            d0[j] = word_t'(j + 1);
            d1[j] = word_t'(j + 5);
        end
        e.b = d0;
        e.a = d1;
        send(d0, d1, fill(0), e, hs_c);
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            @(negedge clk);
            check($sformatf("key_idx_step%0d", i), 64'(key_idx),
                  64'((i < NUM_DIGITS) ? i : 0));
        end
        wait_valid(v_c);
        check("latency", 64'(v_c - hs_c), 64'(NUM_DIGITS + 2));
        wait_drain(50);

        // D2 = 9 -> digits 1,2,0; key_B[i] = 4**i, key_A = 0.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            kb_rom[i] = fill(4 ** i);
            ka_rom[i] = fill(0);
        end
        e.b = fill(2);
        e.a = fill(3);
        send(fill(10), fill(3), fill(9), e, hs_c);
        wait_drain(50);

        // D2 = 16 -> digits 0,0,1; only digit 2 keys nonzero (16).
        for (int i = 0; i < NUM_DIGITS; i++) begin
            kb_rom[i] = fill((i == 2) ? 16 : 0);
            ka_rom[i] = fill((i == 2) ? 16 : 0);
        end
        e.b = fill(15);
        e.a = fill(16);
        send(fill(16), fill(0), fill(16), e, hs_c);
        wait_drain(50);

        // Output stall: hold out_ready low for 6 cycles after out_valid.
        rand_keys();
        d0 = rand_vec();
        d1 = rand_vec();
        d2 = rand_vec();
        out_ready = 1'b0;
        send(d0, d1, d2, model(d0, d1, d2), hs_c);
        wait_valid(v_c);
        held = out_ct;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_out_ct",    64'(out_ct),    64'(held));
            check("stall_in_ready",  64'(in_ready),  64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("post_stall_in_ready",  64'(in_ready),  64'(1));
        check("post_stall_out_valid", 64'(out_valid), 64'(0));
        check("post_stall_pending",   64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;

        // Reset in the middle of decomposition, then a clean transaction.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            kb_rom[i] = fill(4 ** i);
            ka_rom[i] = fill(0);
        end
        send(rand_vec(), rand_vec(), rand_vec(), '0, hs_c);
        @(negedge clk);
        @(negedge clk);
        check("abort_key_idx_before", 64'(key_idx), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_in_ready",  64'(in_ready),  64'(1));
        check("abort_key_idx",   64'(key_idx),   64'(0));
        @(posedge clk);
        #1;
        e.b = fill(2);
        e.a = fill(3);
        send(fill(10), fill(3), fill(9), e, hs_c);
        wait_drain(50);

        // Long random run with random backpressure.
        rand_keys();
        base_count = out_count;
        rand_ready = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            d0 = rand_vec();
            d1 = rand_vec();
            d2 = rand_vec();
            send(d0, d1, d2, model(d0, d1, d2), hs_c);
        end
        wait_drain(400);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        check("random_output_count", 64'(out_count - base_count), 64'(1000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
